// File: rtl/spinnaker_link_receiver_pkg.sv
// Shared constants for the SpiNNaker 2-of-7 link receiver: symbol encoding,
// code table, packet field layout and small decode helpers.
package spinnaker_link_receiver_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int PKT_W       = 72;
    localparam int HDR_LSB     = 0;
    localparam int HDR_MSB     = 7;
    localparam int KEY_LSB     = 8;
    localparam int KEY_MSB     = 39;
    localparam int PLD_LSB     = 40;
    localparam int PLD_MSB     = 71;
    localparam int HDR_PLD_BIT = 1;

    localparam logic [4:0] SHORT_FLITS = 5'd10;
    localparam logic [4:0] LONG_FLITS  = 5'd18;

    // Decoded symbol is {is_eop, nibble}
    localparam logic [4:0] SYM_EOP = 5'b1_0000;

    typedef enum logic [1:0] {
        FLIT_NONE,
        FLIT_SYM,
        FLIT_ERR
    } flit_kind_e;

    typedef enum logic {
        ST_WAKE,
        ST_RUN
    } rx_state_e;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Returns {legal, symbol}; legal=0 for any code outside the table
    function automatic logic [5:0] code_to_sym(input logic [6:0] code);
        logic [5:0] r;
        case (code)
            7'h11:   r = {1'b1, 5'h00};
            7'h12:   r = {1'b1, 5'h01};
            7'h14:   r = {1'b1, 5'h02};
            7'h18:   r = {1'b1, 5'h03};
            7'h21:   r = {1'b1, 5'h04};
            7'h22:   r = {1'b1, 5'h05};
            7'h24:   r = {1'b1, 5'h06};
            7'h28:   r = {1'b1, 5'h07};
            7'h41:   r = {1'b1, 5'h08};
            7'h42:   r = {1'b1, 5'h09};
            7'h44:   r = {1'b1, 5'h0A};
            7'h48:   r = {1'b1, 5'h0B};
            7'h03:   r = {1'b1, 5'h0C};
            7'h06:   r = {1'b1, 5'h0D};
            7'h0C:   r = {1'b1, 5'h0E};
            7'h09:   r = {1'b1, 5'h0F};
            7'h60:   r = {1'b1, SYM_EOP};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spinnaker_link_receiver_if.sv
// Link-side and fabric-side signals of the receiver; master is the
// environment (link transmitter + packet consumer), slave is the receiver.
interface spinnaker_link_receiver_if;
    import spinnaker_link_receiver_pkg::*;

    logic [6:0]       SL_DATA_2OF7_IN;
    logic             SL_ACK_OUT;
    logic [PKT_W-1:0] PKT_DATA_OUT;
    logic             PKT_VLD_OUT;
    logic             PKT_RDY_IN;

    modport master (
        output SL_DATA_2OF7_IN,
        output PKT_RDY_IN,
        input  SL_ACK_OUT,
        input  PKT_DATA_OUT,
        input  PKT_VLD_OUT
    );

    modport slave (
        input  SL_DATA_2OF7_IN,
        input  PKT_RDY_IN,
        output SL_ACK_OUT,
        output PKT_DATA_OUT,
        output PKT_VLD_OUT
    );

endinterface

// File: rtl/spinnaker_link_flit_decoder.sv
// Classifies the change between the synchronised link value and the last
// accepted value: nothing yet, a legal symbol, or an error flit.
module spinnaker_link_flit_decoder
    import spinnaker_link_receiver_pkg::*;
(
    input  logic [6:0] sync_i,
    input  logic [6:0] old_i,
    output flit_kind_e kind_o,
    output logic [4:0] sym_o
);

    logic [6:0] diff;
    logic [2:0] ones;
    logic [5:0] lookup;

    assign diff   = sync_i ^ old_i;
    assign ones   = popcount7(diff);
    assign lookup = code_to_sym(diff);

    // A single-bit difference is a transition still propagating through the
    // synchroniser, so it is not yet a flit.
    always_comb begin
        kind_o = FLIT_NONE;
        sym_o  = '0;
        if (ones > 3'd2) begin
            kind_o = FLIT_ERR;
        end else if (ones == 3'd2) begin
            if (lookup[5]) begin
                kind_o = FLIT_SYM;
                sym_o  = lookup[4:0];
            end else begin
                kind_o = FLIT_ERR;
            end
        end
    end

endmodule

// File: rtl/spinnaker_link_receiver.sv
// SpiNNaker 2-of-7 link receiver: synchronises the NRZ link, acks flits,
// assembles short/long packets and hands good ones to a one-entry output.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_WAKE | post-reset delay; ack toggles to 1 on exit, no flits accepted
// ST_RUN  | decoding flits, assembling packets, loading the output entry
module spinnaker_link_receiver
    import spinnaker_link_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic                      tb_clk,
    input logic                      tb_rst,
    spinnaker_link_receiver_if.slave link
);

    localparam logic [1:0] WAKE_CNT_INIT = 2'd1;

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  sync;

    rx_state_e        state_q, state_d;
    logic [1:0]       wake_cnt_q, wake_cnt_d;
    logic             ack_q, ack_d;
    logic [6:0]       old_q, old_d;
    logic [4:0]       flit_cnt_q, flit_cnt_d;
    logic             bad_q, bad_d;
    logic [PKT_W-1:0] asm_q, asm_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic             vld_q, vld_d;

    flit_kind_e kind;
    logic [4:0] sym;
    logic [6:0] nib_base;
    logic       out_free;
    logic       eop_good;
    logic       take;

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= link.SL_DATA_2OF7_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    spinnaker_link_flit_decoder u_decoder (
        .sync_i (sync),
        .old_i  (old_q),
        .kind_o (kind),
        .sym_o  (sym)
    );

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q    <= ST_WAKE;
            wake_cnt_q <= WAKE_CNT_INIT;
            ack_q      <= 1'b0;
            old_q      <= '0;
            flit_cnt_q <= '0;
            bad_q      <= 1'b0;
            asm_q      <= '0;
            pkt_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            ack_q      <= ack_d;
            old_q      <= old_d;
            flit_cnt_q <= flit_cnt_d;
            bad_q      <= bad_d;
            asm_q      <= asm_d;
            pkt_q      <= pkt_d;
            vld_q      <= vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        ack_d      = ack_q;
        old_d      = old_q;
        flit_cnt_d = flit_cnt_q;
        bad_d      = bad_q;
        asm_d      = asm_q;
        pkt_d      = pkt_q;
        vld_d      = vld_q;
        take       = 1'b0;
        nib_base   = {flit_cnt_q, 2'b00};
        // The entry is free if empty or being consumed this very cycle.
        out_free   = !vld_q || link.PKT_RDY_IN;
        eop_good   = !bad_q &&
                     (((flit_cnt_q == SHORT_FLITS) && !asm_q[HDR_PLD_BIT]) ||
                      ((flit_cnt_q == LONG_FLITS)  &&  asm_q[HDR_PLD_BIT]));

        if (vld_q && link.PKT_RDY_IN) begin
            vld_d = 1'b0;
        end

        case (state_q)
            ST_WAKE: begin
                if (wake_cnt_q == '0) begin
                    ack_d   = ~ack_q;
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - 2'd1;
                end
            end
            ST_RUN: begin
                case (kind)
                    FLIT_ERR: begin
                        take  = 1'b1;
                        bad_d = 1'b1;
                    end
                    FLIT_SYM: begin
                        if (sym == SYM_EOP) begin
                            // A good EOP with a full entry stays un-acked until it frees.
                            if (!eop_good || out_free) begin
                                take       = 1'b1;
                                flit_cnt_d = '0;
                                bad_d      = 1'b0;
                            end
                            if (eop_good && out_free) begin
                                vld_d = 1'b1;
                                if (asm_q[HDR_PLD_BIT]) begin
                                    pkt_d = asm_q;
                                end else begin
                                    pkt_d = {{(PLD_MSB-PLD_LSB+1){1'b0}}, asm_q[KEY_MSB:HDR_LSB]};
                                end
                            end
                        end else begin
                            take = 1'b1;
                            if (flit_cnt_q < LONG_FLITS) begin
                                asm_d[nib_base +: NIBBLE_W] = sym[NIBBLE_W-1:0];
                                flit_cnt_d                  = flit_cnt_q + 5'd1;
                            end else begin
                                bad_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        if (take) begin
            old_d = sync;
            ack_d = ~ack_q;
        end
    end

    assign link.SL_ACK_OUT   = ack_q;
    assign link.PKT_DATA_OUT = pkt_q;
    assign link.PKT_VLD_OUT  = vld_q;

endmodule

// File: tb/tb_spinnaker_link_receiver.sv
// Self-checking bench: a link transmitter model sends packets, a consumer
// drains the fabric side, and a queue of expected packets scores the output.
module tb_spinnaker_link_receiver;

    localparam logic [6:0] NIB_CODE [16] = '{
        7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
        7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09
    };
    localparam logic [6:0] EOP_CODE     = 7'h60;
    localparam logic [6:0] ERR_CODE [4] = '{7'h13, 7'h05, 7'h7F, 7'h30};

    logic tb_clk;
    logic tb_rst;

    spinnaker_link_receiver_if bus ();

    spinnaker_link_receiver #(.SYNC_STAGES(2)) dut (
        .tb_clk (tb_clk),
        .tb_rst (tb_rst),
        .link   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  tx_data;
    int          rdy_mode;
    logic        cons_rdy;
    bit          held;
    logic [71:0] held_data;
    logic [71:0] exp_data;
    logic [71:0] exp_q [$];

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Consumer: owns PKT_RDY_IN, scores every handshake and checks holding.
    always @(negedge tb_clk) begin
        if (tb_rst) begin
            held           = 1'b0;
            cons_rdy       = (rdy_mode == 0);
            bus.PKT_RDY_IN = cons_rdy;
        end else begin
            if (held) begin
                check_val("hold_vld", 72'(bus.PKT_VLD_OUT), 72'd1);
                check_val("hold_data", bus.PKT_DATA_OUT, held_data);
            end
            case (rdy_mode)
                0:       cons_rdy = 1'b1;
                1:       cons_rdy = 1'b0;
                default: cons_rdy = ($urandom_range(0, 3) != 0);
            endcase
            bus.PKT_RDY_IN = cons_rdy;
            if (bus.PKT_VLD_OUT && cons_rdy) begin
                check_val("pkt_was_expected", 72'(exp_q.size() != 0), 72'd1);
                if (exp_q.size() != 0) begin
                    exp_data = exp_q.pop_front();
                    check_val("pkt_data", bus.PKT_DATA_OUT, exp_data);
                end
            end
            held      = bus.PKT_VLD_OUT && !cons_rdy;
            held_data = bus.PKT_DATA_OUT;
        end
    end

    task automatic send_flit(input logic [6:0] code, input int budget, input string tag);
        logic a0;
        int   n;
        a0                  = bus.SL_ACK_OUT;
        tx_data             = tx_data ^ code;
        bus.SL_DATA_2OF7_IN = tx_data;
        if (budget > 0) begin
            n = 0;
            while (bus.SL_ACK_OUT === a0 && n < budget) begin
                @(negedge tb_clk);
                n++;
            end
            check_val(tag, 72'(bus.SL_ACK_OUT !== a0), 72'd1);
        end
    endtask

    // nibs holds data flits LS nibble first; err_at<0 means no error flit,
    // otherwise an error flit goes just before data flit err_at (or the EOP).
    task automatic send_packet(input logic [79:0] nibs, input int n, input int err_at,
                               input logic [6:0] err_code, input int eop_budget);
        bit          good;
        logic [71:0] expv;
        good = (err_at < 0) && ((n == 10 && !nibs[1]) || (n == 18 && nibs[1]));
        expv = nibs[1] ? nibs[71:0] : {32'h0, nibs[39:0]};
        for (int i = 0; i < n; i++) begin
            if (i == err_at) send_flit(err_code, 4, "err_flit_ack");
            send_flit(NIB_CODE[nibs[4*i +: 4]], 4, "data_flit_ack");
        end
        if (err_at == n) send_flit(err_code, 4, "err_flit_ack");
        if (good) exp_q.push_back(expv);
        send_flit(EOP_CODE, eop_budget, "eop_ack");
    endtask

    task automatic do_reset();
        int n;
        tb_rst              = 1'b1;
        tx_data             = '0;
        bus.SL_DATA_2OF7_IN = '0;
        repeat (3) @(negedge tb_clk);
        check_val("rst_ack", 72'(bus.SL_ACK_OUT), 72'd0);
        check_val("rst_vld", 72'(bus.PKT_VLD_OUT), 72'd0);
        check_val("rst_data", bus.PKT_DATA_OUT, 72'd0);
        tb_rst = 1'b0;
        n = 0;
        while (bus.SL_ACK_OUT !== 1'b1 && n < 8) begin
            @(negedge tb_clk);
            n++;
        end
        check_val("ready_toggle_2_to_4", 72'(bus.SL_ACK_OUT === 1'b1 && n >= 2 && n <= 4), 72'd1);
        check_val("ready_no_vld", 72'(bus.PKT_VLD_OUT), 72'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge tb_clk);
            n++;
        end
        check_val({tag, "_delivered"}, 72'(exp_q.size()), 72'd0);
        repeat (3) @(negedge tb_clk);
        check_val({tag, "_vld_clear"}, 72'(bus.PKT_VLD_OUT), 72'd0);
    endtask

    task automatic backpressure_test();
        logic a0;
        int   n;
        rdy_mode = 1;
        send_packet({8'h0, 72'h00000000_12345678_00}, 10, -1, 7'h0, 4);
        send_packet({8'h0, 72'hCAFEF00D_87654321_02}, 18, -1, 7'h0, 0);
        a0 = bus.SL_ACK_OUT;
        repeat (30) @(negedge tb_clk);
        check_val("bp_eop_withheld", 72'(bus.SL_ACK_OUT), 72'(a0));
        check_val("bp_first_held", bus.PKT_DATA_OUT, 72'h00000000_12345678_00);
        repeat (170) @(negedge tb_clk);
        rdy_mode = 0;
        n = 0;
        while (bus.SL_ACK_OUT === a0 && n < 20) begin
            @(negedge tb_clk);
            n++;
        end
        check_val("bp_eop_released", 72'(bus.SL_ACK_OUT !== a0), 72'd1);
        send_packet({8'h0, 72'h00000000_0BADBEEF_01}, 10, -1, 7'h0, 4);
        drain("bp");
    endtask

    task automatic reset_mid_op_test();
        rdy_mode = 1;
        send_packet({8'h0, 72'h00000000_11112222_00}, 10, -1, 7'h0, 4);
        for (int i = 0; i < 5; i++) send_flit(NIB_CODE[i], 4, "partial_ack");
        do_reset();
        exp_q.delete();
        rdy_mode = 0;
        repeat (5) @(negedge tb_clk);
        check_val("mid_rst_no_vld", 72'(bus.PKT_VLD_OUT), 72'd0);
        send_packet({8'h0, 72'h00000000_33334444_00}, 10, -1, 7'h0, 4);
        drain("after_rst");
    endtask

    task automatic random_test(input int npkt);
        logic [79:0] nibs;
        int          n;
        int          err_at;
        int          kind;
        rdy_mode = 2;
        for (int p = 0; p < npkt; p++) begin
            nibs = {16'($urandom), $urandom, $urandom};
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                nibs[1] = 1'b0;
                n       = 10;
            end else if (kind <= 7) begin
                nibs[1] = 1'b1;
                n       = 18;
            end else if (kind == 8) begin
                n = $urandom_range(0, 20);
            end else begin
                nibs[1] = 1'b1;
                n       = 10;
            end
            err_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
            send_packet(nibs, n, err_at, ERR_CODE[$urandom_range(0, 3)], 64);
        end
        drain("random");
    endtask

    initial begin
        tb_rst              = 1'b1;
        tx_data             = '0;
        bus.SL_DATA_2OF7_IN = '0;
        rdy_mode            = 0;
        do_reset();

        send_packet({8'h0, 72'h00000000_00000001_00}, 10, -1, 7'h0, 4);
        drain("short");
        send_packet({8'h0, 72'hA5A5A5B4_0000000F_03}, 18, -1, 7'h0, 4);
        drain("long");

        backpressure_test();

        send_packet({8'h0, 72'h00000000_DEADBEEF_00}, 10, 5, 7'h13, 4);
        send_packet({8'h0, 72'h00000000_5EEDF00D_00}, 10, -1, 7'h0, 4);
        drain("err_flit");

        send_packet({8'h0, 72'h00000000_00ABCDEF_00}, 6, -1, 7'h0, 4);
        send_packet({8'h0, 72'h00000000_76543210_00}, 10, -1, 7'h0, 4);
        drain("short_count");

        send_packet({8'hFF, 72'h12345678_9ABCDEF0_02}, 20, -1, 7'h0, 4);
        send_packet({8'h0, 72'h00000000_CCCCDDDD_02}, 10, -1, 7'h0, 4);
        send_packet({8'h0, 72'hFFFF0000_AAAA5555_01}, 18, -1, 7'h0, 4);
        send_packet({8'h0, 72'h00000000_13579BDF_01}, 10, -1, 7'h0, 4);
        drain("bad_len");

        reset_mid_op_test();
        random_test(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: run still active at 2000000 ns, limit 2000000 ns");
        $fatal(1, "time limit reached");
    end

endmodule
